// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: CP0 exception codes,
// the exception handler entry point and the default Tnew width.
package cpu_pkg;

    // CP0 Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Exception handler entry point
    localparam logic [31:0] CPU_HANDLER_PC = 32'h0000_4180;

    // Width of the Tnew hazard counter carried down the pipe
    localparam int CPU_TNEW_W = 2;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, upstream and registered signals between two stages.
// master = the surrounding pipeline, slave = the stage register itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W  = 64,
    parameter int NUM_EXC = 3,
    parameter int TNEW_W  = cpu_pkg::CPU_TNEW_W
);
    logic                req;
    logic                stall;
    logic                flush;
    logic [31:0]         in_instr;
    logic [31:0]         in_pc;
    logic [4:0]          in_wa;
    logic [DATA_W-1:0]   in_payload;
    logic [TNEW_W-1:0]   in_tnew;
    logic                in_bd;
    logic [4:0]          in_exc;
    logic [NUM_EXC-1:0]  exc_src;

    logic [31:0]         out_instr;
    logic [31:0]         out_pc;
    logic [4:0]          out_wa;
    logic [DATA_W-1:0]   out_payload;
    logic [TNEW_W-1:0]   out_tnew;
    logic                out_bd;
    logic [4:0]          out_exc;
    logic                out_valid;

    modport master (
        output req, stall, flush, in_instr, in_pc, in_wa, in_payload,
               in_tnew, in_bd, in_exc, exc_src,
        input  out_instr, out_pc, out_wa, out_payload, out_tnew, out_bd,
               out_exc, out_valid
    );

    modport slave (
        input  req, stall, flush, in_instr, in_pc, in_wa, in_payload,
               in_tnew, in_bd, in_exc, exc_src,
        output out_instr, out_pc, out_wa, out_payload, out_tnew, out_bd,
               out_exc, out_valid
    );
endinterface

// File: rtl/pipe_stage_reg_exc_prio_enc.sv
// Merges the exception code carried from earlier stages with this stage's
// local exception flags. An earlier-stage code always wins; among local
// sources the lowest asserted index wins.
module exc_prio_enc #(
    parameter int                     NUM_EXC   = 3,
    parameter logic [NUM_EXC*5-1:0]   EXC_CODES = {5'd5, 5'd4, 5'd12}
) (
    input  logic [4:0]          in_exc_i,
    input  logic [NUM_EXC-1:0]  exc_src_i,
    output logic [4:0]          exc_code_o
);

    logic [4:0] local_code_s;

    // Pick the local code of the lowest asserted source, then let an
    // already-carried code override it.
    always_comb begin
        local_code_s = 5'd0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_src_i[i]) begin
                local_code_s = EXC_CODES[5*i +: 5];
            end else begin
                local_code_s = local_code_s;
            end
        end
        if (in_exc_i != 5'd0) begin
            exc_code_o = in_exc_i;
        end else begin
            exc_code_o = local_code_s;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register. One edge performs exactly one of
// reset > req > stall > flush > load. All outputs come straight from flops.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int                     DATA_W     = 64,
    parameter int                     NUM_EXC    = 3,
    parameter logic [NUM_EXC*5-1:0]   EXC_CODES  = {EXC_ADES, EXC_ADEL, EXC_OV},
    parameter int                     TNEW_W     = CPU_TNEW_W,
    parameter bit                     TNEW_DEC   = 1'b1,
    parameter logic [31:0]            HANDLER_PC = CPU_HANDLER_PC
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_reg_if.slave   bus
);

    logic [31:0]        instr_q;
    logic [31:0]        pc_q;
    logic [4:0]         wa_q;
    logic [DATA_W-1:0]  payload_q;
    logic [TNEW_W-1:0]  tnew_q;
    logic               bd_q;
    logic [4:0]         exc_q;
    logic               valid_q;

    logic [TNEW_W-1:0]  tnew_d;
    logic [4:0]         exc_d;

    exc_prio_enc #(
        .NUM_EXC   (NUM_EXC),
        .EXC_CODES (EXC_CODES)
    ) u_exc_prio_enc (
        .in_exc_i   (bus.in_exc),
        .exc_src_i  (bus.exc_src),
        .exc_code_o (exc_d)
    );

    // Tnew value on load: saturating decrement or straight pass-through.
    always_comb begin
        tnew_d = bus.in_tnew;
        if (TNEW_DEC) begin
            if (bus.in_tnew == {TNEW_W{1'b0}}) begin
                tnew_d = {TNEW_W{1'b0}};
            end else begin
                tnew_d = bus.in_tnew - {{(TNEW_W-1){1'b0}}, 1'b1};
            end
        end else begin
            tnew_d = bus.in_tnew;
        end
    end

    // Register bank, one priority-ordered action per edge. A bubble keeps
    // PC and BD so CP0 still gets a correct EPC if an interrupt lands on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= 32'd0;
            pc_q      <= 32'd0;
            wa_q      <= 5'd0;
            payload_q <= {DATA_W{1'b0}};
            tnew_q    <= {TNEW_W{1'b0}};
            bd_q      <= 1'b0;
            exc_q     <= 5'd0;
            valid_q   <= 1'b0;
        end else if (bus.req) begin
            instr_q   <= 32'd0;
            pc_q      <= HANDLER_PC;
            wa_q      <= 5'd0;
            payload_q <= {DATA_W{1'b0}};
            tnew_q    <= {TNEW_W{1'b0}};
            bd_q      <= 1'b0;
            exc_q     <= 5'd0;
            valid_q   <= 1'b0;
        end else if (bus.stall) begin
            instr_q   <= instr_q;
            pc_q      <= pc_q;
            wa_q      <= wa_q;
            payload_q <= payload_q;
            tnew_q    <= tnew_q;
            bd_q      <= bd_q;
            exc_q     <= exc_q;
            valid_q   <= valid_q;
        end else if (bus.flush) begin
            instr_q   <= 32'd0;
            pc_q      <= bus.in_pc;
            wa_q      <= 5'd0;
            payload_q <= {DATA_W{1'b0}};
            tnew_q    <= {TNEW_W{1'b0}};
            bd_q      <= bus.in_bd;
            exc_q     <= 5'd0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= bus.in_instr;
            pc_q      <= bus.in_pc;
            wa_q      <= bus.in_wa;
            payload_q <= bus.in_payload;
            tnew_q    <= tnew_d;
            bd_q      <= bus.in_bd;
            exc_q     <= exc_d;
            valid_q   <= 1'b1;
        end
    end

    assign bus.out_instr   = instr_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_wa      = wa_q;
    assign bus.out_payload = payload_q;
    assign bus.out_tnew    = tnew_q;
    assign bus.out_bd      = bd_q;
    assign bus.out_exc     = exc_q;
    assign bus.out_valid   = valid_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance (Tnew decrement,
// three local exception sources) and a second instance with Tnew
// pass-through and a single local exception source.
module tb_pipe_stage_reg;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(64), .NUM_EXC(3), .TNEW_W(2)) ifa ();
    pipe_stage_reg_if #(.DATA_W(16), .NUM_EXC(1), .TNEW_W(2)) ifb ();

    pipe_stage_reg #(
        .DATA_W(64), .NUM_EXC(3), .EXC_CODES({5'd5, 5'd4, 5'd12}),
        .TNEW_W(2), .TNEW_DEC(1'b1), .HANDLER_PC(32'h0000_4180)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    pipe_stage_reg #(
        .DATA_W(16), .NUM_EXC(1), .EXC_CODES(5'd10),
        .TNEW_W(2), .TNEW_DEC(1'b0), .HANDLER_PC(32'h0000_4180)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [4:0] wa, input logic [63:0] payload,
                         input logic [1:0] tnew, input logic bd,
                         input logic [4:0] exc, input logic [2:0] src);
        ifa.in_instr   = instr;
        ifa.in_pc      = pc;
        ifa.in_wa      = wa;
        ifa.in_payload = payload;
        ifa.in_tnew    = tnew;
        ifa.in_bd      = bd;
        ifa.in_exc     = exc;
        ifa.exc_src    = src;
    endtask

    task automatic ctl_a(input logic req, input logic stall, input logic flush);
        ifa.req   = req;
        ifa.stall = stall;
        ifa.flush = flush;
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero_but_pc(input string tag, input logic [31:0] pc);
        check({tag, "_instr"},   ifa.out_instr,   64'd0);
        check({tag, "_pc"},      ifa.out_pc,      {32'd0, pc});
        check({tag, "_wa"},      ifa.out_wa,      64'd0);
        check({tag, "_payload"}, ifa.out_payload, 64'd0);
        check({tag, "_tnew"},    ifa.out_tnew,    64'd0);
        check({tag, "_bd"},      ifa.out_bd,      64'd0);
        check({tag, "_exc"},     ifa.out_exc,     64'd0);
        check({tag, "_valid"},   ifa.out_valid,   64'd0);
    endtask

    initial begin
        // Reset for two cycles with arbitrary inputs
        reset = 1'b1;
        ctl_a(1'b1, 1'b1, 1'b1);
        set_a(32'hDEAD_BEEF, 32'hCAFE_0000, 5'd9, 64'h1234_5678_9ABC_DEF0, 2'd3, 1'b1, 5'd7, 3'b111);
        ifb.req = 1'b0; ifb.stall = 1'b0; ifb.flush = 1'b0;
        ifb.in_instr = 32'hFFFF_FFFF; ifb.in_pc = 32'h1; ifb.in_wa = 5'd3;
        ifb.in_payload = 16'hABCD; ifb.in_tnew = 2'd3; ifb.in_bd = 1'b1;
        ifb.in_exc = 5'd0; ifb.exc_src = 1'b1;
        #2;
        step();
        step();
        check_a_zero_but_pc("reset", 32'd0);
        check("reset_b_tnew",  ifb.out_tnew,  64'd0);
        check("reset_b_valid", ifb.out_valid, 64'd0);

        // First load after reset release
        reset = 1'b0;
        ctl_a(1'b0, 1'b0, 1'b0);
        set_a(32'h8C01_0004, 32'h0000_3004, 5'd1, 64'h0000_0000_0000_00AA, 2'd2, 1'b0, 5'd0, 3'b000);
        ifb.in_tnew = 2'd3; ifb.in_exc = 5'd0; ifb.exc_src = 1'b1;
        step();
        check("load_pc",     ifa.out_pc,      64'h3004);
        check("load_tnew",   ifa.out_tnew,    64'd1);
        check("load_valid",  ifa.out_valid,   64'd1);
        check("load_instr",  ifa.out_instr,   64'h8C01_0004);
        check("load_wa",     ifa.out_wa,      64'd1);
        check("load_pay",    ifa.out_payload, 64'hAA);
        check("load_exc",    ifa.out_exc,     64'd0);
        check("b_tnew_pass", ifb.out_tnew,    64'd3);
        check("b_exc_local", ifb.out_exc,     64'd10);
        check("b_payload",   ifb.out_payload, 64'hABCD);

        // Exception merging
        ifa.in_exc = 5'd0; ifa.exc_src = 3'b110;
        ifb.exc_src = 1'b0; ifb.in_tnew = 2'd0;
        step();
        check("exc_src110", ifa.out_exc, 64'd4);
        check("b_exc_none", ifb.out_exc, 64'd0);
        check("b_tnew0",    ifb.out_tnew, 64'd0);
        ifa.in_exc = 5'd10; ifa.exc_src = 3'b001;
        ifb.in_exc = 5'd5;  ifb.exc_src = 1'b1;
        step();
        check("exc_carried", ifa.out_exc, 64'd10);
        check("b_exc_carry", ifb.out_exc, 64'd5);
        ifa.in_exc = 5'd0; ifa.exc_src = 3'b111;
        step();
        check("exc_src111", ifa.out_exc, 64'd12);
        ifa.exc_src = 3'b000;
        step();
        check("exc_none", ifa.out_exc, 64'd0);

        // Tnew saturation
        ifa.in_tnew = 2'd0;
        step();
        check("tnew_sat0", ifa.out_tnew, 64'd0);
        ifa.in_tnew = 2'd3;
        step();
        check("tnew_dec3", ifa.out_tnew, 64'd2);

        // Bubble
        ctl_a(1'b0, 1'b0, 1'b1);
        set_a(32'hFFFF_FFFF, 32'h0000_3010, 5'd31, 64'h5555_5555_5555_5555, 2'd3, 1'b1, 5'd5, 3'b111);
        step();
        check("flush_instr", ifa.out_instr,   64'd0);
        check("flush_valid", ifa.out_valid,   64'd0);
        check("flush_pc",    ifa.out_pc,      64'h3010);
        check("flush_bd",    ifa.out_bd,      64'd1);
        check("flush_wa",    ifa.out_wa,      64'd0);
        check("flush_pay",   ifa.out_payload, 64'd0);
        check("flush_tnew",  ifa.out_tnew,    64'd0);
        check("flush_exc",   ifa.out_exc,     64'd0);

        // Reload known contents, then stall three cycles with changing inputs
        ctl_a(1'b0, 1'b0, 1'b0);
        set_a(32'h1111_1111, 32'h0000_3020, 5'd7, 64'h0102_0304_0506_0708, 2'd2, 1'b0, 5'd0, 3'b010);
        step();
        check("reload_valid", ifa.out_valid, 64'd1);
        check("reload_exc",   ifa.out_exc,   64'd4);
        for (int k = 0; k < 3; k++) begin
            ctl_a(1'b0, 1'b1, (k == 1));
            set_a(32'h2222_0000 + k, 32'h0000_4000 + 4 * k, 5'(k + 10), 64'hFFFF_0000 + k,
                  2'(k + 1), 1'b1, 5'(k + 1), 3'b100);
            step();
            check("stall_instr", ifa.out_instr,   64'h1111_1111);
            check("stall_pc",    ifa.out_pc,      64'h3020);
            check("stall_wa",    ifa.out_wa,      64'd7);
            check("stall_pay",   ifa.out_payload, 64'h0102_0304_0506_0708);
            check("stall_tnew",  ifa.out_tnew,    64'd1);
            check("stall_bd",    ifa.out_bd,      64'd0);
            check("stall_exc",   ifa.out_exc,     64'd4);
            check("stall_valid", ifa.out_valid,   64'd1);
        end

        // Request during stall wins
        ctl_a(1'b1, 1'b1, 1'b0);
        step();
        check_a_zero_but_pc("req", 32'h0000_4180);

        // Load again, then reset together with req
        ctl_a(1'b0, 1'b0, 1'b0);
        set_a(32'h3333_3333, 32'h0000_3030, 5'd2, 64'd99, 2'd1, 1'b1, 5'd0, 3'b000);
        step();
        check("load2_pc", ifa.out_pc, 64'h3030);
        reset = 1'b1;
        ctl_a(1'b1, 1'b0, 1'b0);
        step();
        check_a_zero_but_pc("rst_req", 32'd0);

        // Reset mid-stall, then hold, then load
        reset = 1'b0;
        ctl_a(1'b0, 1'b0, 1'b0);
        step();
        check("pre_stall_valid", ifa.out_valid, 64'd1);
        reset = 1'b1;
        ctl_a(1'b0, 1'b1, 1'b0);
        step();
        check_a_zero_but_pc("rst_stall", 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_hold_pc",    ifa.out_pc,    64'd0);
        check("post_rst_hold_valid", ifa.out_valid, 64'd0);
        ctl_a(1'b0, 1'b0, 1'b0);
        step();
        check("post_rst_load_pc",    ifa.out_pc,    64'h3030);
        check("post_rst_load_valid", ifa.out_valid, 64'd1);
        check("post_rst_load_tnew",  ifa.out_tnew,  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
